// File: rtl/flag_unit.sv
// flag_unit: ADD/SUB/AND/ORR datapath with NZCV derivation and the
// architectural flag register. The condition checker's verdict (cond_ok)
// gates every flag write; logical operations never touch C and V.
module flag_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [1:0]       alu_ctrl,
  input  logic [1:0]       flag_write,
  input  logic             cond_ok,
  output logic [WIDTH-1:0] alu_result,
  output logic [3:0]       alu_flags,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             V
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             is_arith;
  logic             flag_n;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;
  logic             write_nz;
  logic             write_cv;

  // Shared adder: SUB is A + ~B + 1, so bit 0 of alu_ctrl doubles as carry-in
  always_comb begin
    is_arith = ~alu_ctrl[1];
    b_eff    = alu_ctrl[0] ? ~src_b : src_b;
    sum_ext  = {1'b0, src_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, alu_ctrl[0]};
    sum      = sum_ext[WIDTH-1:0];
    cout     = sum_ext[WIDTH];
  end

  // Result mux: adder output for ADD/SUB, bitwise ops otherwise
  always_comb begin
    alu_result = sum;
    case (alu_ctrl)
      2'b10:   alu_result = src_a & src_b;
      2'b11:   alu_result = src_a | src_b;
      default: alu_result = sum;
    endcase
  end

  // Flag derivation; C and V read zero for logical operations
  always_comb begin
    flag_n    = alu_result[WIDTH-1];
    flag_z    = (alu_result == '0);
    flag_c    = is_arith & cout;
    flag_v    = is_arith & (src_a[WIDTH-1] == b_eff[WIDTH-1]) &
                (sum[WIDTH-1] != src_a[WIDTH-1]);
    alu_flags = {flag_n, flag_z, flag_c, flag_v};
  end

  // Independent write enables for the N/Z pair and the C/V pair
  always_comb begin
    write_nz = flag_write[1] & cond_ok;
    write_cv = flag_write[0] & cond_ok & is_arith;
  end

  // Architectural flag register; reset overrides any simultaneous write
  always_ff @(posedge clk) begin
    if (reset) begin
      N <= 1'b0;
      Z <= 1'b0;
      C <= 1'b0;
      V <= 1'b0;
    end else begin
      if (write_nz) begin
        N <= flag_n;
        Z <= flag_z;
      end
      if (write_cv) begin
        C <= flag_c;
        V <= flag_v;
      end
    end
  end

endmodule

// File: doc/flag_unit.md
# flag_unit

Producer side of the processor's NZCV condition-flag path. Performs the 32-bit ADD/SUB/AND/ORR datapath operation, derives the N, Z, C and V flags from it, and holds them in the architectural flag register. The condition checker reads the registered flags; its satisfied verdict comes back to gate every flag write.

## Interface
- WIDTH, 32, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; clears the flag register
- src_a  input  WIDTH  operand A
- src_b  input  WIDTH  operand B
- alu_ctrl  input  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- flag_write  input  2  bit1 = write N,Z; bit0 = write C,V (instruction S-bit decode)
- cond_ok  input  1  condition-check verdict for the current instruction
- alu_result  output  WIDTH  combinational operation result
- alu_flags  output  4  combinational {N,Z,C,V} of the current operation
- N, Z, C, V  output  1 each  registered architectural flags

## Operation
- One clock; reset is synchronous and active-high.
- Arithmetic (alu_ctrl[1]=0):
  - b_eff = src_b for ADD, ~src_b for SUB.
  - {cout, sum} = src_a + b_eff + alu_ctrl[0], computed at WIDTH+1 bits.
  - SUB C=1 means no borrow.
- Logical operations:
  - AND gives src_a & src_b; ORR gives src_a | src_b.
  - alu_flags C and V read 0.
- Flag derivation:
  - N = alu_result[WIDTH-1].
  - Z = (alu_result == 0).
  - C = cout.
  - V = (src_a[MSB] == b_eff[MSB]) & (sum[MSB] != src_a[MSB]).
- Register update, at each rising edge when reset=0:
  - N,Z load alu_flags N,Z when flag_write[1] & cond_ok.
  - C,V load alu_flags C,V when flag_write[0] & cond_ok & ~alu_ctrl[1]. Logical operations never modify C,V, even when flag_write[0]=1.
  - Otherwise each flag holds its value.
- Enables are independent. Any combination of flag_write bits is legal, including 2'b01.
- cond_ok=0 suppresses all flag writes. alu_result and alu_flags still reflect the inputs.

## Timing
- reset=1 at a rising edge: N=Z=C=V=0 after that edge, regardless of other inputs. Reset overrides any simultaneous write.
- alu_result and alu_flags are purely combinational from src_a, src_b and alu_ctrl; zero latency. They do not depend on reset.
- Flag register latency is one cycle. A write enabled in cycle k is visible on N/Z/C/V in cycle k+1. The checker therefore evaluates instruction k+1 against the flags produced by instruction k.
- No bypass: a flag-setting instruction's own cond_ok is computed from the pre-update flags.
- cond_ok must be stable before the rising edge. It is sampled only at the edge.
- Reset deasserted mid-stream: the first edge with reset=0 performs a normal update.
- Width and wrap-around:
  - The result is truncated to WIDTH bits.
  - Carry comes only from bit WIDTH.
  - ADD 0xFFFFFFFF+1 gives result 0, Z=1, C=1, V=0.

## Test plan
- **Reset:** after writes leave N=Z=C=V=1, assert reset with flag_write=11, cond_ok=1 → next cycle N=Z=C=V=0.
- **SUB equal operands:** src_a=src_b=5, alu_ctrl=01, flag_write=11, cond_ok=1 → alu_result=0; next cycle N=0 Z=1 C=1 V=0.
- **Signed overflow:** ADD 0x7FFFFFFF+1, flag_write=11 → result 0x80000000; next cycle N=1 Z=0 C=0 V=1.
- **SUB with borrow:** SUB 3-5 → result 0xFFFFFFFE; next cycle N=1 Z=0 C=0 V=0.
- **Logical op preserves C,V:** from C=1,V=1, AND 0xF0 & 0x0F with flag_write=11 → next cycle Z=1 N=0, C=1 V=1 unchanged.
- **Suppressed writes:**
  - cond_ok=0 with flag_write=11 on ADD 0xFFFFFFFF+1 → flags unchanged, while alu_flags shows {0,1,1,0} combinationally.
  - Separately, flag_write=10 → only N,Z change.
